adc_seq: RTL and testbench
==========================

ADC_SEQ -- requirements
Module: adc_seq

Interface
REQ-001 SHALL have parameter TOUT, default 255, meaning the cycles allowed waiting on fd_spi before aborting a frame.
REQ-002 SHALL have parameter DUMMY_CMD, default 16'hE800, meaning the command sent in the two flush slots (read register 40).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  frame-start pulse.
REQ-006 chan_num  input  6  channels per frame, sampled on accepted start.
REQ-007 busy  output  1  high while a frame is in progress.
REQ-008 done  output  1  one-cycle pulse at frame end.
REQ-009 err  output  1  one-cycle pulse when a frame is aborted by timeout.
REQ-010 fs  output  1  transaction request to the spi stage.
REQ-011 chip_txd  output  16  command word to the spi stage.
REQ-012 chip_rxd  input  32  captured result from the spi stage: [31:16] chip A, [15:0] chip B.
REQ-013 fd_spi  input  1  spi transaction finished, held until fs drops.
REQ-014 fd_prd  input  1  spi stage idle in its DONE state (monitor only).
REQ-015 data_a, data_b  output  16 each  per-channel samples.
REQ-016 data_chan  output  5  channel index of the samples.
REQ-017 data_valid  output  1  one-cycle strobe qualifying data_a, data_b and data_chan.

Function
REQ-018 Accepted start (IDLE only) SHALL latch N = chan_num, with 0 giving 0 and values above 32 clamped to 32; start while busy SHALL be ignored.
REQ-019 N = 0 SHALL pulse done on the cycle after start, with no fs activity.
REQ-020 A frame SHALL issue N+2 transactions, k = 0..N+1: k<N sends CONVERT {2'b00, k[5:0], 8'h00}; k>=N sends DUMMY_CMD.
REQ-021 FSM states SHALL be IDLE -> LOAD -> REQ -> CAPT -> REL -> NEXT -> (LOAD | DONE) -> IDLE.
REQ-022 LOAD SHALL drive chip_txd for transaction k; chip_txd SHALL stay stable from LOAD until REL exits.
REQ-023 REQ SHALL hold fs=1 until fd_spi=1, then go to CAPT.
REQ-024 CAPT (1 cycle) SHALL, if k>=2, register data_a = chip_rxd[31:16], data_b = chip_rxd[15:0], data_chan = k-2, and pulse data_valid the next cycle.
REQ-025 REL SHALL drive fs=0 and wait for fd_spi=0 before NEXT; fs SHALL be low for at least 1 cycle between transactions.
REQ-026 NEXT SHALL increment k; if k == N+1 (last) go to DONE, else go to LOAD.
REQ-027 DONE SHALL pulse done for 1 cycle, then go to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-028 A watchdog counter SHALL clear on entry to REQ/REL and count while waiting; reaching TOUT SHALL force fs=0, pulse err (no done), and return to IDLE.
REQ-029 Exactly N data_valid pulses SHALL occur per completed frame, with data_chan 0..N-1 ascending.
REQ-030 fd_prd SHALL NOT affect sequencing.

Reset
REQ-031 rst SHALL force IDLE in any state, including mid-transaction.
REQ-032 Reset values SHALL be fs=0, chip_txd=0, busy=0, done=0, err=0, data_valid=0, data_a=0, data_b=0, data_chan=0, k=0, N=0, watchdog=0.
REQ-033 After reset, the first accepted start SHALL be the one sampled on the cycle after rst deasserts.

Structure
REQ-034 The shared adc package SHALL hold the state encodings, the CONVERT opcode (2'b00), DUMMY_CMD, and the maximum channel count 32.
REQ-035 The block SHALL be a single module with no sub-modules; the spi stage is instantiated alongside it by the parent.

Verification
REQ-036 chan_num=4 with a spi model loopback returning {txd,~txd} -> commands 0000, 0100, 0200, 0300, E800, E800; 4 data_valid, chans 0..3, data_a = 0000, 0100, 0200, 0300 (two-slot lag); done once.
REQ-037 chan_num=0 -> done on the cycle after start, fs never high, busy back to 0 on the following cycle.
REQ-038 chan_num=40 -> clamped to 32: 34 transactions, 32 data_valid, last data_chan=31.
REQ-039 fd_spi held 0 for 300 cycles -> fs drops at cycle TOUT, err pulses, no done, busy=0, next start accepted.
REQ-040 rst asserted during REQ of k=2 -> next cycle fs=0, busy=0, all outputs at reset values; a new start runs a full frame.
REQ-041 start pulsed again mid-frame -> ignored; transaction count unchanged.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC frame sequencer: state encoding, command
// opcodes and the channel-count limit.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StReq  = 3'd2,
    StCapt = 3'd3,
    StRel  = 3'd4,
    StNext = 3'd5,
    StDone = 3'd6
  } adc_state_e;

  localparam logic [1:0]  OpConvert = 2'b00;
  // Read of register 40; used to flush the two-deep result pipeline.
  localparam logic [15:0] DummyCmd  = 16'hE800;
  localparam int unsigned MaxChan   = 32;

  // Requested channel count limited to what one frame can carry.
  function automatic logic [5:0] clamp_chan(logic [5:0] c);
    return (c > 6'(MaxChan)) ? 6'(MaxChan) : c;
  endfunction

  // Command for slot k of an n-channel frame: converts first, then flushes.
  function automatic logic [15:0] slot_cmd(logic [5:0] k, logic [5:0] n, logic [15:0] dummy);
    return (k < n) ? {OpConvert, k, 8'h00} : dummy;
  endfunction

endpackage

// File: rtl/adc_seq.sv
// ADC frame sequencer: issues N conversions plus two flush reads to the spi
// stage and returns each result (two slots late) as a per-channel sample.
module adc_seq
  import adc_seq_pkg::*;
#(
  parameter int unsigned TOUT      = 255,
  parameter logic [15:0] DUMMY_CMD = DummyCmd
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  chan_num,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        fs,
  output logic [15:0] chip_txd,
  input  logic [31:0] chip_rxd,
  input  logic        fd_spi,
  input  logic        fd_prd,
  output logic [15:0] data_a,
  output logic [15:0] data_b,
  output logic [4:0]  data_chan,
  output logic        data_valid
);

  // Watchdog counts 0..TOUT-1; fs is high for exactly TOUT cycles on a hang.
  localparam int unsigned WdW = (TOUT < 2) ? 1 : $clog2(TOUT);
  localparam logic [WdW-1:0] WdLast = WdW'(TOUT - 1);

  adc_state_e     state_q, state_d;
  logic [5:0]     k_q, k_d;
  logic [5:0]     n_q, n_d;
  logic [15:0]    txd_q, txd_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           dv_q, dv_d;
  logic [15:0]    da_q, da_d;
  logic [15:0]    db_q, db_d;
  logic [4:0]     dch_q, dch_d;
  logic [5:0]     n_req;

  // fd_prd is a status monitor only and never steers sequencing.
  logic unused_fd_prd;
  assign unused_fd_prd = fd_prd;

  assign n_req = clamp_chan(chan_num);

  // Next-state, slot counter, watchdog and sample capture.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    txd_d   = txd_q;
    wd_d    = wd_q;
    err_d   = 1'b0;
    dv_d    = 1'b0;
    da_d    = da_q;
    db_d    = db_q;
    dch_d   = dch_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          n_d = n_req;
          k_d = 6'd0;
          if (n_req == 6'd0) begin
            state_d = StDone;
          end else begin
            // Command is set up on entry so it is already valid during LOAD.
            txd_d   = slot_cmd(6'd0, n_req, DUMMY_CMD);
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        wd_d    = '0;
        state_d = StReq;
      end
      StReq: begin
        if (fd_spi) begin
          state_d = StCapt;
        end else if (wd_q == WdLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StCapt: begin
        // Results lag the commands by two slots; the first two are discarded.
        if (k_q >= 6'd2) begin
          da_d  = chip_rxd[31:16];
          db_d  = chip_rxd[15:0];
          dch_d = 5'(k_q - 6'd2);
          dv_d  = 1'b1;
        end
        wd_d    = '0;
        state_d = StRel;
      end
      StRel: begin
        if (!fd_spi) begin
          state_d = StNext;
        end else if (wd_q == WdLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StNext: begin
        if (k_q == n_q + 6'd1) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + 6'd1;
          txd_d   = slot_cmd(k_q + 6'd1, n_q, DUMMY_CMD);
          state_d = StLoad;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      n_q     <= '0;
      txd_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      da_q    <= '0;
      db_q    <= '0;
      dch_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      txd_q   <= txd_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
      da_q    <= da_d;
      db_q    <= db_d;
      dch_q   <= dch_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign fs         = (state_q == StReq);
  assign err        = err_q;
  assign chip_txd   = txd_q;
  assign data_a     = da_q;
  assign data_b     = db_q;
  assign data_chan  = dch_q;
  assign data_valid = dv_q;

endmodule

// File: tb/tb_adc_seq.sv
// Directed bench for adc_seq with a loopback spi responder that returns
// {cmd, ~cmd} of the command issued two transactions earlier.
module tb_adc_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  chan_num;
  logic        busy, done, err, fs;
  logic [15:0] chip_txd;
  logic [31:0] chip_rxd;
  logic        fd_spi;
  logic        fd_prd;
  logic [15:0] data_a, data_b;
  logic [4:0]  data_chan;
  logic        data_valid;

  int checks = 0;
  int errors = 0;

  // Responder / monitor state
  logic [15:0] cmds[$];
  logic [15:0] dv_a[$];
  logic [15:0] dv_b[$];
  logic [4:0]  dv_ch[$];
  int          done_cnt;
  int          err_cnt;
  bit          hang;
  bit          fs_prev;
  int          dly;

  adc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .chan_num   (chan_num),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .fs         (fs),
    .chip_txd   (chip_txd),
    .chip_rxd   (chip_rxd),
    .fd_spi     (fd_spi),
    .fd_prd     (fd_prd),
    .data_a     (data_a),
    .data_b     (data_b),
    .data_chan  (data_chan),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // spi stage model plus output monitor, all on the falling edge
  initial begin
    int idx;
    fd_spi   = 1'b0;
    chip_rxd = '0;
    fd_prd   = 1'b0;
    fs_prev  = 1'b0;
    dly      = 0;
    done_cnt = 0;
    err_cnt  = 0;
    forever begin
      @(negedge clk);
      fd_prd = 1'($urandom_range(0, 1));
      if (fs && !fs_prev) begin
        cmds.push_back(chip_txd);
        dly = 2;
      end
      if (data_valid) begin
        dv_a.push_back(data_a);
        dv_b.push_back(data_b);
        dv_ch.push_back(data_chan);
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (fs && !fd_spi && !hang) begin
        if (dly == 0) begin
          idx = cmds.size() - 1;
          chip_rxd = (idx >= 2) ? {cmds[idx-2], ~cmds[idx-2]} : 32'hDEAD_BEEF;
          fd_spi = 1'b1;
        end else begin
          dly--;
        end
      end else if (!fs && fd_spi) begin
        fd_spi = 1'b0;
      end
      fs_prev = fs;
    end
  end

  task automatic clear_mon();
    cmds.delete();
    dv_a.delete();
    dv_b.delete();
    dv_ch.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // Start is sampled on the posedge that follows; returns at #1 after it.
  task automatic pulse_start(input logic [5:0] n);
    @(posedge clk);
    #1;
    chan_num = n;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (fs !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", fs); end
    checks++; if (chip_txd !== 16'h0000) begin errors++; $display("FAIL reset_txd: got %h want 0000", chip_txd); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", data_valid); end
    checks++;
    if ({data_a, data_b, data_chan} !== 37'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h want 0", data_a, data_b, data_chan);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_chan();
    clear_mon();
    pulse_start(6'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_len: got %b want 0", done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmds.size() != 0) begin errors++; $display("FAIL zero_fs: got %0d txns want 0", cmds.size()); end
  endtask

  task automatic test_frame4();
    logic [15:0] exp_cmd[6] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'hE800, 16'hE800};
    logic [15:0] exp_a[4]   = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
    logic [15:0] exp_b[4]   = '{16'hFFFF, 16'hFEFF, 16'hFDFF, 16'hFCFF};
    bit ok;
    clear_mon();
    pulse_start(6'd4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL f4_busy: got %b want 1", busy); end
    checks++; if (chip_txd !== 16'h0000) begin errors++; $display("FAIL f4_load_txd: got %h want 0000", chip_txd); end
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL f4_done_timeout: got none want done"); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL f4_idle: got busy=%b want 0", busy); end
    checks++; if (cmds.size() != 6) begin errors++; $display("FAIL f4_txns: got %0d want 6", cmds.size()); end
    for (int i = 0; i < 6 && i < cmds.size(); i++) begin
      checks++;
      if (cmds[i] !== exp_cmd[i]) begin
        errors++; $display("FAIL f4_cmd%0d: got %h want %h", i, cmds[i], exp_cmd[i]);
      end
    end
    checks++; if (dv_a.size() != 4) begin errors++; $display("FAIL f4_dv_count: got %0d want 4", dv_a.size()); end
    for (int i = 0; i < 4 && i < dv_a.size(); i++) begin
      checks++;
      if (dv_ch[i] !== 5'(i) || dv_a[i] !== exp_a[i] || dv_b[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL f4_sample%0d: got ch=%0d a=%h b=%h want ch=%0d a=%h b=%h",
                 i, dv_ch[i], dv_a[i], dv_b[i], i, exp_a[i], exp_b[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL f4_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL f4_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_clamp();
    bit ok;
    clear_mon();
    pulse_start(6'd40);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clamp_done_timeout: got none want done"); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmds.size() != 34) begin errors++; $display("FAIL clamp_txns: got %0d want 34", cmds.size()); end
    checks++; if (dv_ch.size() != 32) begin errors++; $display("FAIL clamp_dv: got %0d want 32", dv_ch.size()); end
    if (cmds.size() == 34) begin
      checks++;
      if (cmds[31] !== 16'h1F00 || cmds[32] !== 16'hE800 || cmds[33] !== 16'hE800) begin
        errors++; $display("FAIL clamp_tail_cmds: got %h %h %h want 1f00 e800 e800",
                           cmds[31], cmds[32], cmds[33]);
      end
    end
    if (dv_ch.size() == 32) begin
      checks++;
      if (dv_ch[31] !== 5'd31 || dv_a[31] !== 16'h1F00) begin
        errors++; $display("FAIL clamp_last: got ch=%0d a=%h want ch=31 a=1f00", dv_ch[31], dv_a[31]);
      end
    end
  endtask

  task automatic test_timeout();
    int fs_cycles;
    bit ok;
    clear_mon();
    hang = 1'b1;
    pulse_start(6'd2);
    fs_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (fs) fs_cycles++;
      else if (fs_cycles > 0) break;
    end
    checks++; if (fs_cycles != 255) begin errors++; $display("FAIL to_fs_cycles: got %0d want 255", fs_cycles); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", busy); end
    @(posedge clk);
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_len: got %b want 0", err); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL to_no_done: got %0d want 0", done_cnt); end
    hang = 1'b0;
    clear_mon();
    pulse_start(6'd1);
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_restart: got no done want done"); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dv_a.size() != 1) begin errors++; $display("FAIL to_restart_dv: got %0d want 1", dv_a.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit ok;
    clear_mon();
    pulse_start(6'd4);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fs && chip_txd == 16'h0200) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rm_reach_k2: got no REQ want REQ k=2"); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (fs !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rm_idle: got fs=%b busy=%b want 0 0", fs, busy);
    end
    checks++; if (chip_txd !== 16'h0 || data_b !== 16'h0 || data_a !== 16'h0 || data_chan !== 5'h0) begin
      errors++; $display("FAIL rm_outputs: got txd=%h a=%h b=%h ch=%0d want 0", chip_txd, data_a, data_b, data_chan);
    end
    // Release reset and present start together: it must be the one accepted.
    clear_mon();
    chan_num = 6'd4;
    rst      = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_first_start: got busy=%b want 1", busy); end
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_done_timeout: got none want done"); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmds.size() != 6 || dv_a.size() != 4) begin
      errors++; $display("FAIL rm_frame: got txns=%0d dv=%0d want 6 4", cmds.size(), dv_a.size());
    end
    if (dv_a.size() == 4) begin
      checks++;
      if (dv_a[3] !== 16'h0300 || dv_ch[3] !== 5'd3) begin
        errors++; $display("FAIL rm_last: got a=%h ch=%0d want 0300 3", dv_a[3], dv_ch[3]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    pulse_start(6'd2);
    repeat (5) @(posedge clk);
    #1;
    pulse_start(6'd10);
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: got none want done"); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmds.size() != 4) begin errors++; $display("FAIL b2b_txns: got %0d want 4", cmds.size()); end
    checks++; if (dv_a.size() != 2) begin errors++; $display("FAIL b2b_dv: got %0d want 2", dv_a.size()); end
    clear_mon();
    pulse_start(6'd1);
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second: got none want done"); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmds.size() != 3 || dv_ch.size() != 1) begin
      errors++; $display("FAIL b2b_second_frame: got txns=%0d dv=%0d want 3 1", cmds.size(), dv_ch.size());
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    chan_num = 6'd0;
    hang     = 1'b0;
    test_reset();
    test_zero_chan();
    test_frame4();
    test_clamp();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
